pe_feeder: RTL and testbench

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_pkg.sv | 24 ++
 rtl/psum_buf.sv | 51 +++++
 rtl/pe_feeder.sv | 170 +++++++++++++++++
 tb/tb_pe_feeder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and sizing constants for the PE feeder.
package pe_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned IFMAP_DEPTH = 12;
  localparam int unsigned FILT_DEPTH  = 256;
  localparam int unsigned PSUM_DEPTH  = 32;
  localparam int unsigned PTR_W       = 5;

  typedef enum logic [2:0] {
    StIdle,
    StLoadF,
    StLoadI,
    StCompute,
    StCapture,
    StDrain
  } state_e;

  // True when a zero-based counter is on the final item of an n-item run.
  function automatic logic is_last(logic [8:0] cnt, logic [8:0] n);
    return cnt == (n - 9'd1);
  endfunction

endpackage

// File: rtl/psum_buf.sv
// 32-entry psum FIFO; pointers wrap naturally, occupancy tracked separately.
module psum_buf
  import pe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [PSUM_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign w_push  = i_push && (r_count < (PTR_W+1)'(PSUM_DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];

  // Storage array; data needs no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping; clear empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// Sequences one PE pass: filter load, ifmap load, compute, psum capture, drain.
module pe_feeder
  import pe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [4:0]        P,
  input  logic [2:0]        Q,
  input  logic [3:0]        S,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] pe_data,
  output logic              load_f,
  output logic              load_i,
  output logic              start,
  input  logic              compute_complete,
  input  logic [DATA_W-1:0] psum_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e      r_state, w_state_nxt;
  logic [8:0]  r_cnt, w_cnt_nxt;
  logic [8:0]  r_nf;
  logic [6:0]  r_ni;
  logic [4:0]  r_np;
  logic        r_err, r_done;
  logic [11:0] w_nf_full;
  logic [6:0]  w_ni;
  logic        w_cfg_ok;
  logic        w_accept, w_reject, w_last_pop;
  logic        w_push, w_pop, w_clr, w_empty;

  // Full-width product so oversized configs are caught before truncation.
  assign w_nf_full = 12'(P) * 12'(Q) * 12'(S);
  assign w_ni      = 7'(Q) * 7'(S);
  assign w_cfg_ok  = (P != '0) && (Q != '0) && (S != '0) &&
                     (w_nf_full <= 12'(FILT_DEPTH)) && (w_ni <= 7'(IFMAP_DEPTH));

  assign pe_data = in_data;
  assign busy    = (r_state != StIdle);
  assign done    = r_done;
  assign err     = r_err;

  // State, counter, config latch and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_nf    <= '0;
      r_ni    <= '0;
      r_np    <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_reject;
      r_done  <= w_last_pop;
      if (w_accept) begin
        r_nf <= w_nf_full[8:0];
        r_ni <= w_ni;
        r_np <= P;
      end
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    in_ready    = 1'b0;
    load_f      = 1'b0;
    load_i      = 1'b0;
    start       = 1'b0;
    out_valid   = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_last_pop  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (go) begin
          if (w_cfg_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = StLoadF;
            w_cnt_nxt   = '0;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      StLoadF: begin
        in_ready = 1'b1;
        load_f   = in_valid;
        if (in_valid) begin
          if (is_last(r_cnt, r_nf)) begin
            w_state_nxt = StLoadI;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 9'd1;
          end
        end
      end
      StLoadI: begin
        in_ready = 1'b1;
        load_i   = in_valid;
        if (in_valid) begin
          if (is_last(r_cnt, {2'b00, r_ni})) begin
            w_state_nxt = StCompute;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 9'd1;
          end
        end
      end
      StCompute: begin
        start = 1'b1;
        if (compute_complete) begin
          w_state_nxt = StCapture;
          w_clr       = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      StCapture: begin
        w_push = 1'b1;
        if (is_last(r_cnt, {4'b0000, r_np})) begin
          w_state_nxt = StDrain;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
      StDrain: begin
        out_valid = !w_empty;
        if (out_valid && out_ready) begin
          w_pop = 1'b1;
          if (is_last(r_cnt, {4'b0000, r_np})) begin
            w_state_nxt = StIdle;
            w_last_pop  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 9'd1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  psum_buf u_psum_buf (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_wdata (psum_in),
    .i_pop   (w_pop),
    .o_rdata (out_data),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: config table, random passes, corner sequences.
module tb_pe_feeder;

  logic        clk = 1'b0;
  logic        rst, go;
  logic [4:0]  P;
  logic [2:0]  Q;
  logic [3:0]  S;
  logic [15:0] in_data, pe_data, psum_in, out_data;
  logic        in_valid, in_ready, load_f, load_i, start, compute_complete;
  logic        out_valid, out_ready, busy, done, err;

  int n_total = 0;
  int n_bad   = 0;
  logic [1:0] g_pulse = 2'b00;  // {done, err} expected in the next idle-looking cycle

  wire [7:0] w_ctl = {in_ready, load_f, load_i, start, out_valid, busy, done, err};

  pe_feeder dut (
    .clk              (clk),
    .rst              (rst),
    .go               (go),
    .P                (P),
    .Q                (Q),
    .S                (S),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .pe_data          (pe_data),
    .load_f           (load_f),
    .load_i           (load_i),
    .start            (start),
    .compute_complete (compute_complete),
    .psum_in          (psum_in),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    go               = 1'b0;
    in_valid         = 1'($urandom_range(0, 1));
    in_data          = 16'($urandom);
    psum_in          = 16'($urandom);
    compute_complete = 1'($urandom_range(0, 1));
    out_ready        = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      drive_idle();
      #1;
      chk("idle_ctl", 32'(w_ctl), {24'd0, 6'd0, g_pulse});
      g_pulse = 2'b00;
      next_cycle();
    end
  endtask

  task automatic run_err(input int p, input int q, input int s);
    drive_idle();
    go = 1'b1; P = 5'(p); Q = 3'(q); S = 4'(s);
    #1;
    chk("err_go_cycle", 32'(w_ctl), {24'd0, 6'd0, g_pulse});
    g_pulse = 2'b00;
    next_cycle();
    drive_idle();
    #1;
    chk("err_pulse", 32'(w_ctl), 32'h01);
    next_cycle();
    idle_check(2);
  endtask

  // Reference: a pass is NF filter transfers, NI ifmap transfers, compute until the
  // pulse, NP captured psums, then those psums drained in order, then done.
  task automatic run_pass(input int p, input int q, input int s, input int vmode,
                          input int rmode, input int cc_delay, input bit stray_cc,
                          input bit stray_go, input bit abort_loadi);
    int nf, ni, phase, f, i, cc, cap, drn, budget;
    logic [7:0]  exp;
    logic [15:0] q_exp[$];
    nf = p * q * s; ni = q * s;
    phase = 0; f = 0; i = 0; cc = 0; cap = 0; drn = 0; budget = 0;
    drive_idle();
    go = 1'b1; P = 5'(p); Q = 3'(q); S = 4'(s);
    #1;
    chk("go_cycle", 32'(w_ctl), {24'd0, 6'd0, g_pulse});
    g_pulse = 2'b00;
    next_cycle();
    while (phase != 5) begin
      budget++;
      if (budget > 4000) begin
        chk("timeout_phase", 32'(phase), 32'd5);
        return;
      end
      go       = 1'b0;
      in_data  = 16'($urandom);
      psum_in  = 16'($urandom);
      in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(budget % 2) :
                 1'($urandom_range(0, 1));
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(phase == 4 && drn >= 5) :
                  1'($urandom_range(0, 1));
      compute_complete = 1'((phase == 2 && cc == cc_delay) ||
                            (stray_cc && phase == 0 && budget == 1));
      if (stray_go && phase == 2 && cc == 0) begin
        go = 1'b1; P = 5'd1; Q = 3'd1; S = 4'd1;
      end
      rst = 1'(abort_loadi && phase == 1 && i == 0);
      #1;
      case (phase)
        0:       exp = {1'b1, in_valid, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
        1:       exp = {1'b1, 1'b0, in_valid, 1'b0, 1'b0, 1'b1, 2'b00};
        2:       exp = 8'b0001_0100;
        3:       exp = 8'b0000_0100;
        default: exp = 8'b0000_1100;
      endcase
      chk("ctl", 32'(w_ctl), 32'(exp));
      chk("pe_data", 32'(pe_data), 32'(in_data));
      if (phase == 4) chk("out_data", 32'(out_data), 32'(q_exp[0]));
      if (rst) begin
        next_cycle();
        rst = 1'b0;
        drive_idle();
        #1;
        chk("after_rst", 32'(w_ctl), 32'h00);
        next_cycle();
        idle_check(2);
        return;
      end
      case (phase)
        0: if (in_valid) begin f++; if (f == nf) phase = 1; end
        1: if (in_valid) begin i++; if (i == ni) phase = 2; end
        2: if (compute_complete) phase = 3; else cc++;
        3: begin
          q_exp.push_back(psum_in);
          cap++;
          if (cap == p) phase = 4;
        end
        default: begin
          drn++;
          if (out_ready) begin
            void'(q_exp.pop_front());
            if (q_exp.size() == 0) phase = 5;
          end
        end
      endcase
      next_cycle();
    end
    g_pulse = 2'b10;
  endtask

  typedef struct {
    int p, q, s, vmode, rmode;
    bit exp_err;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{2, 1, 3, 0, 0, 1'b0};   // basic pass, in_valid always high
    tbl[1]  = '{2, 1, 3, 1, 0, 1'b0};   // in_valid toggling
    tbl[2]  = '{3, 1, 1, 0, 1, 1'b0};   // out_ready held low 5 drain cycles
    tbl[3]  = '{1, 4, 4, 0, 0, 1'b1};   // NI=16
    tbl[4]  = '{0, 1, 1, 0, 0, 1'b1};
    tbl[5]  = '{1, 0, 2, 0, 0, 1'b1};
    tbl[6]  = '{1, 2, 0, 0, 0, 1'b1};
    tbl[7]  = '{1, 1, 12, 2, 2, 1'b0};  // NI=12 exactly
    tbl[8]  = '{1, 1, 13, 0, 0, 1'b1};  // NI=13
    tbl[9]  = '{21, 3, 4, 2, 2, 1'b0};  // NF=252, NI=12
    tbl[10] = '{22, 3, 4, 0, 0, 1'b1};  // NF=264
    tbl[11] = '{31, 1, 1, 0, 2, 1'b0};  // deepest capture

    rst = 1'b1;
    drive_idle();
    P = '0; Q = '0; S = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    drive_idle();
    #1;
    chk("reset_state", 32'(w_ctl), 32'h00);
    next_cycle();

    for (int k = 0; k < 12; k++) begin
      if (tbl[k].exp_err) run_err(tbl[k].p, tbl[k].q, tbl[k].s);
      else run_pass(tbl[k].p, tbl[k].q, tbl[k].s, tbl[k].vmode, tbl[k].rmode,
                    2, 1'b0, 1'b0, 1'b0);
    end

    // Stray compute_complete in LOAD_F and go during COMPUTE are ignored.
    run_pass(2, 1, 3, 0, 0, 3, 1'b1, 1'b1, 1'b0);
    // Reset during LOAD_I abandons the pass; the next one completes normally.
    run_pass(2, 2, 2, 0, 0, 1, 1'b0, 1'b0, 1'b1);
    run_pass(2, 2, 2, 2, 2, 1, 1'b0, 1'b0, 1'b0);
    // Back-to-back: go issued in the done cycle.
    run_pass(1, 1, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      int p, q, s, ok;
      p = (k % 7 == 3) ? 0 : int'($urandom_range(1, 31));
      q = int'($urandom_range(1, 4));
      s = int'($urandom_range(1, 4));
      ok = (p != 0 && p * q * s <= 256 && q * s <= 12) ? 1 : 0;
      if (ok == 1) run_pass(p, q, s, 2, 2, int'($urandom_range(0, 5)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      else run_err(p, q, s);
    end

    idle_check(2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
